// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared storage register: requests and data in,
// grant, owner and register contents out.
interface dff_bank_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [IDW-1:0]        owner;
  logic [WIDTH-1:0]      q;
  logic [WIDTH-1:0]      qbar;
  logic                  busy;
  logic                  upd;

  modport master (
    output req, wdata,
    input  gnt, owner, q, qbar, busy, upd
  );

  modport slave (
    input  req, wdata,
    output gnt, owner, q, qbar, busy, upd
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit D flip-flop register between NREQ
// requesters, with a settle window after every load.
module dff_bank_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  dff_bank_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NREQ);
  localparam logic [7:0] HOLD_INIT = (HOLD_CYCLES > 0) ? 8'(HOLD_CYCLES - 1) : 8'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   owner_r;
  logic [NREQ-1:0]  gnt_r;
  logic             upd_r;
  logic [7:0]       hold_cnt;
  logic [IDW-1:0]   winner;
  logic             found;
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] q_r;
  logic             load;

  // Rotating-priority scan: first set request at or above rr_ptr, wrapping.
  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    cand   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = IDW'(idx);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign lane = bus.wdata[int'(owner_r)*WIDTH +: WIDTH];
  assign load = (state == ST_GRANT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= '0;
      owner_r  <= '0;
      gnt_r    <= '0;
      upd_r    <= 1'b0;
      hold_cnt <= '0;
    end else begin
      upd_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state          <= ST_GRANT;
            owner_r        <= winner;
            gnt_r          <= '0;
            gnt_r[winner]  <= 1'b1;
          end
        end
        ST_GRANT: begin
          gnt_r    <= '0;
          upd_r    <= 1'b1;
          rr_ptr   <= (owner_r == IDW'(NREQ - 1)) ? '0 : owner_r + 1'b1;
          hold_cnt <= HOLD_INIT;
          state    <= (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (hold_cnt == 8'd0) state <= ST_IDLE;
          else                  hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage register as one D flip-flop cell per bit; reset wins over a
  // pending load, which is how a mid-GRANT reset aborts the write.
  for (genvar b = 0; b < WIDTH; b++) begin : g_dff_cell
    always_ff @(posedge clk) begin
      if (rst)       q_r[b] <= 1'b0;
      else if (load) q_r[b] <= lane[b];
    end
  end

  assign bus.gnt   = gnt_r;
  assign bus.owner = owner_r;
  assign bus.q     = q_r;
  assign bus.qbar  = ~q_r;
  assign bus.busy  = (state != ST_IDLE);
  assign bus.upd   = upd_r;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed bench: a HOLD_CYCLES=2 instance for most scenarios and a
// HOLD_CYCLES=0 instance for back-to-back loads.
module tb_dff_bank_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus  ();
  dff_bank_arbiter_if #(.NREQ(4), .WIDTH(8)) bus0 ();

  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  dff_bank_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [7:0] v);
    bus.wdata[i*8 +: 8] = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req = 4'hF;
    for (int i = 0; i < 4; i++) set_lane(i, 8'hC0 + 8'(i));
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (bus.q !== 8'h00 || bus.qbar !== 8'hFF) begin
        bad++; $display("FAIL reset_q: q=%h qbar=%h want 00/ff", bus.q, bus.qbar);
      end
      total++;
      if (bus.gnt !== 4'b0 || bus.owner !== 2'd0) begin
        bad++; $display("FAIL reset_gnt: gnt=%b owner=%0d want 0000/0", bus.gnt, bus.owner);
      end
      total++;
      if (bus.busy !== 1'b0 || bus.upd !== 1'b0) begin
        bad++; $display("FAIL reset_flags: busy=%b upd=%b want 0/0", bus.busy, bus.upd);
      end
    end
    bus.req = 4'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    set_lane(2, 8'hA5);
    tick();
    total++;
    if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_grant: gnt=%b owner=%0d busy=%b want 0100/2/1",
                      bus.gnt, bus.owner, bus.busy);
    end
    bus.req = 4'b0;  // dropped during GRANT: the write must still happen
    tick();
    total++;
    if (bus.q !== 8'hA5 || bus.qbar !== 8'h5A || bus.upd !== 1'b1) begin
      bad++; $display("FAIL single_load: q=%h qbar=%h upd=%b want a5/5a/1",
                      bus.q, bus.qbar, bus.upd);
    end
    tick();
    total++;
    if (bus.upd !== 1'b0 || bus.busy !== 1'b1) begin
      bad++; $display("FAIL single_hold: upd=%b busy=%b want 0/1", bus.upd, bus.busy);
    end
    tick();
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL single_idle: busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 8'h10 + 8'(i));
    bus.req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] exp_gnt;
      exp_gnt = 4'b0001 << (k % 4);
      tick();
      total++;
      if (bus.gnt !== exp_gnt || bus.owner !== 2'(k % 4)) begin
        bad++; $display("FAIL contention_grant[%0d]: gnt=%b owner=%0d want %b/%0d",
                        k, bus.gnt, bus.owner, exp_gnt, k % 4);
      end
      tick();
      total++;
      if (bus.q !== 8'h10 + 8'(k % 4) || bus.upd !== 1'b1) begin
        bad++; $display("FAIL contention_q[%0d]: q=%h upd=%b want %h/1",
                        k, bus.q, bus.upd, 8'h10 + 8'(k % 4));
      end
      tick();
      tick();
      total++;
      if (bus.gnt !== 4'b0) begin
        bad++; $display("FAIL contention_gap[%0d]: gnt=%b want 0000", k, bus.gnt);
      end
    end
    bus.req = 4'b0;
  endtask

  // Entered in IDLE with rr_ptr=1 after the contention run.
  task automatic test_rotation();
    bus.req = 4'b0010;
    tick();
    total++;
    if (bus.gnt !== 4'b0010) begin
      bad++; $display("FAIL rot_setup: gnt=%b want 0010", bus.gnt);
    end
    bus.req = 4'b0;
    tick(); tick(); tick();
    bus.req = 4'b1010;
    tick();
    total++;
    if (bus.gnt !== 4'b1000 || bus.owner !== 2'd3) begin
      bad++; $display("FAIL rot_first: gnt=%b owner=%0d want 1000/3", bus.gnt, bus.owner);
    end
    tick();
    total++;
    if (bus.q !== 8'h13) begin
      bad++; $display("FAIL rot_first_q: q=%h want 13", bus.q);
    end
    tick(); tick(); tick();
    total++;
    if (bus.gnt !== 4'b0010 || bus.owner !== 2'd1) begin
      bad++; $display("FAIL rot_wrap: gnt=%b owner=%0d want 0010/1", bus.gnt, bus.owner);
    end
    bus.req = 4'b0;
    tick();
    total++;
    if (bus.q !== 8'h11) begin
      bad++; $display("FAIL rot_second_q: q=%h want 11", bus.q);
    end
    tick(); tick();
  endtask

  // Entered in IDLE with rr_ptr=2.
  task automatic test_abort();
    set_lane(0, 8'h77);
    bus.req = 4'b0001;
    tick();
    bus.req = 4'b0;
    tick();
    total++;
    if (bus.q !== 8'h77) begin
      bad++; $display("FAIL abort_setup: q=%h want 77", bus.q);
    end
    tick(); tick();
    set_lane(0, 8'h3C);
    bus.req = 4'b0001;
    tick();
    total++;
    if (bus.gnt !== 4'b0001) begin
      bad++; $display("FAIL abort_grant: gnt=%b want 0001", bus.gnt);
    end
    rst = 1'b1;
    tick();
    total++;
    if (bus.q !== 8'h00 || bus.upd !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== 4'b0) begin
      bad++; $display("FAIL abort_reset: q=%h upd=%b busy=%b gnt=%b want 00/0/0/0000",
                      bus.q, bus.upd, bus.busy, bus.gnt);
    end
    rst = 1'b0;
    bus.req = 4'b0;
    tick();
    total++;
    if (bus.q !== 8'h00 || bus.upd !== 1'b0) begin
      bad++; $display("FAIL abort_no_write: q=%h upd=%b want 00/0", bus.q, bus.upd);
    end
    // rr_ptr back at 0: with lanes 0 and 3 requesting, lane 0 wins.
    set_lane(0, 8'h55);
    set_lane(3, 8'h66);
    bus.req = 4'b1001;
    tick();
    total++;
    if (bus.gnt !== 4'b0001 || bus.owner !== 2'd0) begin
      bad++; $display("FAIL abort_ptr: gnt=%b owner=%0d want 0001/0", bus.gnt, bus.owner);
    end
    bus.req = 4'b0;
    tick();
    total++;
    if (bus.q !== 8'h55) begin
      bad++; $display("FAIL abort_reload: q=%h want 55", bus.q);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] last_q;
    last_q = bus0.q;
    bus0.wdata[7:0] = 8'h40;
    bus0.req = 4'b0001;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (n % 2 == 1) begin
        total++;
        if (bus0.gnt !== 4'b0001 || bus0.upd !== 1'b0 || bus0.q !== last_q) begin
          bad++; $display("FAIL b2b_grant[%0d]: gnt=%b upd=%b q=%h want 0001/0/%h",
                          n, bus0.gnt, bus0.upd, bus0.q, last_q);
        end
      end else begin
        last_q = 8'h40 + 8'(n - 1);
        total++;
        if (bus0.gnt !== 4'b0 || bus0.upd !== 1'b1 || bus0.q !== last_q) begin
          bad++; $display("FAIL b2b_load[%0d]: gnt=%b upd=%b q=%h want 0000/1/%h",
                          n, bus0.gnt, bus0.upd, bus0.q, last_q);
        end
      end
      bus0.wdata[7:0] = 8'h40 + 8'(n);
    end
    bus0.req = 4'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req    = '0;
    bus.wdata  = '0;
    bus0.req   = '0;
    bus0.wdata = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
